// File: rtl/p_mul_seq_pkg.sv
// Shared types and constants for the p_mul request sequencer: FSM states,
// request op codes, legal pack-width encodings.
package p_mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NULL = 2'b00,
        OP_LO   = 2'b01,
        OP_HI   = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    localparam logic [4:0] PW_32 = 5'b00001;
    localparam logic [4:0] PW_16 = 5'b00010;

    function automatic logic pw_legal(input logic [4:0] pw);
        return (pw == PW_32) || (pw == PW_16);
    endfunction

endpackage

// File: rtl/p_mul_seq_if.sv
// Bundle of the request, response and p_mul-side handshakes of p_mul_seq.
// master is the sequencer itself; slave is the issue stage plus p_mul.
interface p_mul_seq_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_pw;
    logic        req_clmul;
    logic [31:0] req_crs1;
    logic [31:0] req_crs2;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;

    logic        mul_valid;
    logic        mul_ready;
    logic        mul_l;
    logic        mul_h;
    logic        mul_clmul;
    logic [4:0]  mul_pw;
    logic [31:0] mul_crs1;
    logic [31:0] mul_crs2;
    logic [31:0] mul_result;

    modport master (
        input  req_valid, req_op, req_pw, req_clmul, req_crs1, req_crs2,
        input  rsp_ready, mul_ready, mul_result,
        output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err,
        output mul_valid, mul_l, mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2
    );

    modport slave (
        output req_valid, req_op, req_pw, req_clmul, req_crs1, req_crs2,
        output rsp_ready, mul_ready, mul_result,
        input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err,
        input  mul_valid, mul_l, mul_h, mul_clmul, mul_pw, mul_crs1, mul_crs2
    );

endinterface

// File: rtl/p_mul_seq_wdog.sv
// Watchdog for one p_mul handshake: counts stalled cycles and flags when the
// count has reached MAX_WAIT-1, at which point the caller aborts.
module p_mul_seq_wdog #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LIMIT);

    // Holds at the limit so a late ready on the limit cycle still sees it.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/p_mul_seq.sv
// Request sequencer in front of p_mul: drives the low and/or high product
// half, assembles a 64-bit result and returns it in one response handshake.
module p_mul_seq
    import p_mul_seq_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        clock,
    input  logic        reset,
    p_mul_seq_if.master sif
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [4:0]  pw_q, pw_d;
    logic        clmul_q, clmul_d;
    logic [31:0] crs1_q, crs1_d;
    logic [31:0] crs2_q, crs2_d;
    logic [31:0] rsp_lo_q, rsp_lo_d;
    logic [31:0] rsp_hi_q, rsp_hi_d;
    logic        rsp_err_q, rsp_err_d;

    logic in_mul;
    logic mul_hs;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign in_mul    = (state_q == ST_LO) || (state_q == ST_HI);
    assign mul_hs    = in_mul && sif.mul_ready;
    assign wd_clear  = !in_mul || mul_hs;
    assign wd_enable = in_mul && !sif.mul_ready;

    p_mul_seq_wdog #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        // NOTE: every _d starts as its _q, so no branch can leave a latch behind.
        state_d   = state_q;
        op_d      = op_q;
        pw_d      = pw_q;
        clmul_d   = clmul_q;
        crs1_d    = crs1_q;
        crs2_d    = crs2_q;
        rsp_lo_d  = rsp_lo_q;
        rsp_hi_d  = rsp_hi_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (sif.req_valid) begin
                    op_d      = op_e'(sif.req_op);
                    pw_d      = sif.req_pw;
                    clmul_d   = sif.req_clmul;
                    crs1_d    = sif.req_crs1;
                    crs2_d    = sif.req_crs2;
                    rsp_lo_d  = '0;
                    rsp_hi_d  = '0;
                    rsp_err_d = 1'b0;
                    if (!pw_legal(sif.req_pw)) begin
                        state_d   = ST_RSP;
                        rsp_err_d = 1'b1;
                    end else begin
                        case (op_e'(sif.req_op))
                            OP_NULL: state_d = ST_RSP;
                            OP_HI:   state_d = ST_HI;
                            default: state_d = ST_LO;
                        endcase
                    end
                end
            end
            ST_LO: begin
                if (sif.mul_ready) begin
                    rsp_lo_d = sif.mul_result;
                    state_d  = (op_q == OP_BOTH) ? ST_HI : ST_RSP;
                end else if (wd_expired) begin
                    state_d   = ST_RSP;
                    rsp_err_d = 1'b1;
                end
            end
            ST_HI: begin
                if (sif.mul_ready) begin
                    rsp_hi_d = sif.mul_result;
                    state_d  = ST_RSP;
                end else if (wd_expired) begin
                    state_d   = ST_RSP;
                    rsp_err_d = 1'b1;
                end
            end
            default: begin
                if (sif.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NULL;
            pw_q      <= '0;
            clmul_q   <= 1'b0;
            crs1_q    <= '0;
            crs2_q    <= '0;
            rsp_lo_q  <= '0;
            rsp_hi_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pw_q      <= pw_d;
            clmul_q   <= clmul_d;
            crs1_q    <= crs1_d;
            crs2_q    <= crs2_d;
            rsp_lo_q  <= rsp_lo_d;
            rsp_hi_q  <= rsp_hi_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Handshake outputs come from state only; req_ready is also held low in reset.
    assign sif.req_ready = (state_q == ST_IDLE) && !reset;
    assign sif.rsp_valid = (state_q == ST_RSP);
    assign sif.mul_valid = in_mul;
    assign sif.mul_l     = (state_q == ST_LO);
    assign sif.mul_h     = (state_q == ST_HI);

    assign sif.rsp_lo    = rsp_lo_q;
    assign sif.rsp_hi    = rsp_hi_q;
    assign sif.rsp_err   = rsp_err_q;
    assign sif.mul_clmul = clmul_q;
    assign sif.mul_pw    = pw_q;
    assign sif.mul_crs1  = crs1_q;
    assign sif.mul_crs2  = crs2_q;

endmodule

// File: tb/tb_p_mul_seq.sv
// Directed bench for p_mul_seq with a stub p_mul whose per-half results and
// stall length are set per test; expected values are hand-computed.
module tb_p_mul_seq;
    import p_mul_seq_pkg::*;

    localparam int unsigned MAX_WAIT = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    p_mul_seq_if sif ();

    p_mul_seq #(
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sif  (sif)
    );

    always #5 clock = ~clock;

    // Stub p_mul: answers after stall_n stalled cycles if the half is enabled.
    logic        rdy_lo = 1'b1;
    logic        rdy_hi = 1'b1;
    int          stall_n = 0;
    int          stall_cnt = 0;
    logic [31:0] res_lo = '0;
    logic [31:0] res_hi = '0;

    assign sif.mul_ready  = sif.mul_valid && (sif.mul_l ? rdy_lo : rdy_hi)
                            && (stall_cnt >= stall_n);
    assign sif.mul_result = !sif.mul_ready ? 32'hDEAD_BEEF
                            : (sif.mul_l ? res_lo : res_hi);

    int tot_valid = 0;
    int tot_lo_hs = 0;
    int tot_hi_hs = 0;
    int onehot_bad = 0;
    int v0, l0, h0;

    always @(posedge clock) begin
        if (reset || !sif.mul_valid || sif.mul_ready) stall_cnt <= 0;
        else stall_cnt <= stall_cnt + 1;
        if (!reset && sif.mul_valid) tot_valid <= tot_valid + 1;
        if (!reset && sif.mul_valid && sif.mul_ready) begin
            if (sif.mul_l) tot_lo_hs <= tot_lo_hs + 1;
            if (sif.mul_h) tot_hi_hs <= tot_hi_hs + 1;
        end
    end

    always @(negedge clock) begin
        if (!reset && sif.mul_valid && (sif.mul_l == sif.mul_h))
            onehot_bad <= onehot_bad + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req_ready"}, 64'(sif.req_ready), 64'd1);
        check({pfx, "_mul_valid"}, 64'(sif.mul_valid), 64'd0);
        check({pfx, "_mul_l"},     64'(sif.mul_l),     64'd0);
        check({pfx, "_mul_h"},     64'(sif.mul_h),     64'd0);
        check({pfx, "_rsp_valid"}, 64'(sif.rsp_valid), 64'd0);
        check({pfx, "_rsp_err"},   64'(sif.rsp_err),   64'd0);
        check({pfx, "_rsp_lo"},    64'(sif.rsp_lo),    64'd0);
        check({pfx, "_rsp_hi"},    64'(sif.rsp_hi),    64'd0);
        check({pfx, "_mul_crs1"},  64'(sif.mul_crs1),  64'd0);
        check({pfx, "_mul_crs2"},  64'(sif.mul_crs2),  64'd0);
        check({pfx, "_mul_pw"},    64'(sif.mul_pw),    64'd0);
        check({pfx, "_mul_clmul"}, 64'(sif.mul_clmul), 64'd0);
    endtask

    // Presents one request for exactly one cycle; returns #1 after the accept edge.
    task automatic start_req(input string tag, input logic [1:0] op,
                             input logic [4:0] pw, input logic cl,
                             input logic [31:0] a, input logic [31:0] b);
        @(posedge clock);
        #1;
        v0 = tot_valid;
        l0 = tot_lo_hs;
        h0 = tot_hi_hs;
        sif.req_valid = 1'b1;
        sif.req_op    = op;
        sif.req_pw    = pw;
        sif.req_clmul = cl;
        sif.req_crs1  = a;
        sif.req_crs2  = b;
        @(negedge clock);
        check({tag, "_req_ready"}, 64'(sif.req_ready), 64'd1);
        @(posedge clock);
        #1;
        sif.req_valid = 1'b0;
    endtask

    // Cycle index (accept cycle = 0) at which rsp_valid is first seen, or -1.
    task automatic wait_rsp(input int first, output int lat);
        lat = -1;
        for (int i = first; i <= 40; i++) begin
            @(negedge clock);
            if (sif.rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack_rsp(input string tag);
        @(posedge clock);
        #1;
        sif.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        sif.rsp_ready = 1'b0;
        @(negedge clock);
        check({tag, "_rsp_valid_after"}, 64'(sif.rsp_valid), 64'd0);
        check({tag, "_req_ready_after"}, 64'(sif.req_ready), 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_cycle_req_ready", 64'(sif.req_ready), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
    endtask

    int lat;

    initial begin
        sif.req_valid  = 1'b0;
        sif.req_op     = '0;
        sif.req_pw     = '0;
        sif.req_clmul  = 1'b0;
        sif.req_crs1   = '0;
        sif.req_crs2   = '0;
        sif.rsp_ready  = 1'b0;

        // Power-on reset.
        @(posedge clock);
        @(negedge clock);
        check("por_req_ready_in_reset", 64'(sif.req_ready), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("por");

        // 32-bit both halves, 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001.
        res_lo = 32'h0000_0001;
        res_hi = 32'hFFFF_FFFE;
        start_req("t1", OP_BOTH, PW_32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clock);
        check("t1_c1_mul_l",    64'(sif.mul_l),    64'd1);
        check("t1_c1_mul_crs1", 64'(sif.mul_crs1), 64'hFFFF_FFFF);
        check("t1_c1_mul_pw",   64'(sif.mul_pw),   64'(PW_32));
        wait_rsp(2, lat);
        check("t1_latency", 64'(lat), 64'd3);
        check("t1_rsp_lo",  64'(sif.rsp_lo),  64'h0000_0001);
        check("t1_rsp_hi",  64'(sif.rsp_hi),  64'hFFFF_FFFE);
        check("t1_rsp_err", 64'(sif.rsp_err), 64'd0);
        check("t1_valid_cycles", 64'(tot_valid - v0), 64'd2);
        check("t1_lo_hs", 64'(tot_lo_hs - l0), 64'd1);
        check("t1_hi_hs", 64'(tot_hi_hs - h0), 64'd1);
        ack_rsp("t1");

        // 16-bit low half only, carry-less: lane0 2*4 = 8.
        res_lo = 32'h0000_0008;
        res_hi = 32'hBAD0_BAD0;
        start_req("t2", OP_LO, PW_16, 1'b1, 32'h0003_0002, 32'h0005_0004);
        @(negedge clock);
        check("t2_c1_mul_l",     64'(sif.mul_l),     64'd1);
        check("t2_c1_mul_h",     64'(sif.mul_h),     64'd0);
        check("t2_c1_mul_clmul", 64'(sif.mul_clmul), 64'd1);
        check("t2_c1_mul_pw",    64'(sif.mul_pw),    64'(PW_16));
        check("t2_c1_mul_crs2",  64'(sif.mul_crs2),  64'h0005_0004);
        wait_rsp(2, lat);
        check("t2_latency", 64'(lat), 64'd2);
        check("t2_rsp_lo",  64'(sif.rsp_lo), 64'h0000_0008);
        check("t2_rsp_hi",  64'(sif.rsp_hi), 64'd0);
        check("t2_lo_hs",   64'(tot_lo_hs - l0), 64'd1);
        check("t2_hi_hs",   64'(tot_hi_hs - h0), 64'd0);
        ack_rsp("t2");

        // High half only with a 5-cycle stall: 0x10000*0x12345678 -> hi 0x1234.
        res_lo  = 32'h55AA_55AA;
        res_hi  = 32'h0000_1234;
        stall_n = 5;
        start_req("t3", OP_HI, PW_32, 1'b0, 32'h0001_0000, 32'h1234_5678);
        @(negedge clock);
        check("t3_c1_mul_h", 64'(sif.mul_h), 64'd1);
        check("t3_c1_mul_l", 64'(sif.mul_l), 64'd0);
        check("t3_c1_req_ready", 64'(sif.req_ready), 64'd0);
        wait_rsp(2, lat);
        check("t3_latency", 64'(lat), 64'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("t3_hold_rsp_valid", 64'(sif.rsp_valid), 64'd1);
            check("t3_hold_rsp_hi",    64'(sif.rsp_hi), 64'h0000_1234);
            check("t3_hold_rsp_lo",    64'(sif.rsp_lo), 64'd0);
            check("t3_hold_req_ready", 64'(sif.req_ready), 64'd0);
        end
        check("t3_lo_hs", 64'(tot_lo_hs - l0), 64'd0);
        check("t3_hi_hs", 64'(tot_hi_hs - h0), 64'd1);
        ack_rsp("t3");
        stall_n = 0;

        // Null op: immediate zero result, previous rsp_hi must be cleared.
        start_req("t4", OP_NULL, PW_32, 1'b0, 32'h1111_1111, 32'h2222_2222);
        wait_rsp(1, lat);
        check("t4_latency", 64'(lat), 64'd1);
        check("t4_rsp_err", 64'(sif.rsp_err), 64'd0);
        check("t4_rsp_hi",  64'(sif.rsp_hi),  64'd0);
        check("t4_rsp_lo",  64'(sif.rsp_lo),  64'd0);
        check("t4_no_mul_valid", 64'(tot_valid - v0), 64'd0);
        ack_rsp("t4");

        // Illegal pack width.
        start_req("t5", OP_BOTH, 5'b00100, 1'b0, 32'h3, 32'h5);
        wait_rsp(1, lat);
        check("t5_latency", 64'(lat), 64'd1);
        check("t5_rsp_err", 64'(sif.rsp_err), 64'd1);
        check("t5_no_mul_valid", 64'(tot_valid - v0), 64'd0);
        ack_rsp("t5");

        // Watchdog: p_mul never answers, abort after 8 cycles in LO.
        rdy_lo = 1'b0;
        start_req("t6", OP_LO, PW_32, 1'b0, 32'h7, 32'h9);
        wait_rsp(1, lat);
        check("t6_latency", 64'(lat), 64'd9);
        check("t6_rsp_err", 64'(sif.rsp_err), 64'd1);
        check("t6_rsp_lo",  64'(sif.rsp_lo),  64'd0);
        check("t6_valid_cycles", 64'(tot_valid - v0), 64'd8);
        check("t6_lo_hs", 64'(tot_lo_hs - l0), 64'd0);
        ack_rsp("t6");

        // Ready arrives on the limit cycle: 0xFFFF*3 = 0x2FFFD, no error.
        rdy_lo  = 1'b1;
        stall_n = 7;
        res_lo  = 32'h0002_FFFD;
        start_req("t7", OP_LO, PW_32, 1'b0, 32'h0000_FFFF, 32'h0000_0003);
        wait_rsp(1, lat);
        check("t7_latency", 64'(lat), 64'd9);
        check("t7_rsp_err", 64'(sif.rsp_err), 64'd0);
        check("t7_rsp_lo",  64'(sif.rsp_lo),  64'h0002_FFFD);
        check("t7_lo_hs", 64'(tot_lo_hs - l0), 64'd1);
        ack_rsp("t7");
        stall_n = 0;

        // Abort in HI keeps the already captured low half.
        rdy_hi = 1'b0;
        res_lo = 32'hA5A5_0001;
        start_req("t8", OP_BOTH, PW_32, 1'b0, 32'h1, 32'h1);
        wait_rsp(1, lat);
        check("t8_latency", 64'(lat), 64'd10);
        check("t8_rsp_err", 64'(sif.rsp_err), 64'd1);
        check("t8_rsp_lo",  64'(sif.rsp_lo),  64'hA5A5_0001);
        check("t8_rsp_hi",  64'(sif.rsp_hi),  64'd0);
        check("t8_valid_cycles", 64'(tot_valid - v0), 64'd9);
        ack_rsp("t8");

        // Reset while waiting in HI.
        start_req("t9", OP_HI, PW_16, 1'b1, 32'hCAFE_0001, 32'hBEEF_0002);
        @(negedge clock);
        @(negedge clock);
        check("t9_in_hi_mul_h", 64'(sif.mul_h), 64'd1);
        pulse_reset();
        check_reset_vals("t9_rst_hi");
        check("t9_hi_hs", 64'(tot_hi_hs - h0), 64'd0);
        rdy_hi = 1'b1;

        // Follow-up after reset: 3*0x80000000 = 0x1_80000000.
        res_lo = 32'h8000_0000;
        res_hi = 32'h0000_0001;
        start_req("t10", OP_BOTH, PW_32, 1'b0, 32'h3, 32'h8000_0000);
        wait_rsp(1, lat);
        check("t10_latency", 64'(lat), 64'd3);
        check("t10_rsp_lo", 64'(sif.rsp_lo), 64'h8000_0000);
        check("t10_rsp_hi", 64'(sif.rsp_hi), 64'h0000_0001);
        check("t10_rsp_err", 64'(sif.rsp_err), 64'd0);
        ack_rsp("t10");

        // Reset while the response is pending.
        res_lo = 32'h0000_0077;
        start_req("t11", OP_LO, PW_32, 1'b0, 32'h7, 32'h11);
        wait_rsp(1, lat);
        check("t11_latency", 64'(lat), 64'd2);
        check("t11_rsp_lo", 64'(sif.rsp_lo), 64'h0000_0077);
        pulse_reset();
        check_reset_vals("t11_rst_rsp");

        // Follow-up after reset: 0x00010001^2 = 0x1_00020001.
        res_lo = 32'h0002_0001;
        res_hi = 32'h0000_0001;
        start_req("t12", OP_BOTH, PW_32, 1'b0, 32'h0001_0001, 32'h0001_0001);
        wait_rsp(1, lat);
        check("t12_latency", 64'(lat), 64'd3);
        check("t12_rsp_lo", 64'(sif.rsp_lo), 64'h0002_0001);
        check("t12_rsp_hi", 64'(sif.rsp_hi), 64'h0000_0001);
        ack_rsp("t12");

        check("mul_l_h_onehot", 64'(onehot_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p_mul_seq.md
# p_mul_seq

Request sequencer that sits between the issue stage and the `p_mul` packed multiplier, acting as the initiator side of its valid/ready interface. It accepts one request carrying operands, pack width, carry-less flag and an op selector. It then drives `p_mul` once or twice, for the low and/or high product halves, and returns the assembled 64-bit result with a single response handshake. A watchdog aborts requests whose `p_mul` handshake never completes.

## Interface
- `MAX_WAIT`, 64: maximum cycles `mul_valid` may stay high without `mul_ready` before abort (legal range 2..255).
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_op` in 2: 01 low half only, 10 high half only, 11 both, 00 null.
- `req_pw` in 5: one-hot pack width; only 00001 (32-bit) and 00010 (16-bit) are legal.
- `req_clmul` in 1: carry-less multiply flag, forwarded unchanged.
- `req_crs1`, `req_crs2` in 32 each: operands.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_lo`, `rsp_hi` out 32 each: product halves; an unrequested half reads 0.
- `rsp_err` out 1: illegal `pw` or watchdog abort.
- `mul_valid` out 1: request to `p_mul`.
- `mul_ready` in 1: `p_mul` result valid this cycle.
- `mul_l`, `mul_h` out 1 each: half select; exactly one is high while `mul_valid` is high.
- `mul_clmul` out 1, `mul_pw` out 5, `mul_crs1`/`mul_crs2` out 32 each: registered copies of the request fields.
- `mul_result` in 32: `p_mul` result, sampled only on `mul_valid && mul_ready`.

## Operation
- FSM states: IDLE, LO, HI, RSP.
- IDLE
  - `req_ready`=1.
  - On accept, capture all `req_*` fields and clear `rsp_lo`, `rsp_hi`, `rsp_err`.
  - Next state:
    - `req_pw` illegal: RSP with `rsp_err`=1.
    - op=00: RSP with zero result.
    - op=01 or 11: LO.
    - op=10: HI.
- LO
  - `mul_valid`=1, `mul_l`=1.
  - On `mul_ready`: `rsp_lo` ← `mul_result`; next state is HI if op=11, else RSP.
- HI
  - `mul_valid`=1, `mul_h`=1.
  - On `mul_ready`: `rsp_hi` ← `mul_result`; next state RSP.
- RSP
  - `rsp_valid`=1; outputs stay stable until `rsp_ready`, then IDLE.
- `mul_*` operand, pw and clmul outputs are constant from accept until return to IDLE. `mul_l`/`mul_h` change only in the cycle after a `p_mul` handshake.
- LO→HI keeps `mul_valid` high continuously. Each `valid && ready` cycle is one completed `p_mul` operation.
- Watchdog
  - An 8-bit counter clears on entry to LO or HI and increments each cycle in LO/HI without `mul_ready`.
  - When the counter reaches `MAX_WAIT-1` with no `mul_ready`: next state RSP, `rsp_err`=1, already captured halves kept.
  - `mul_ready` in the same cycle as the limit wins; no error is raised.
- `mul_ready` while `mul_valid`=0 is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready`=0 during the reset cycle, 1 from the next cycle.
  - `mul_valid`=0, `mul_l`=0, `mul_h`=0.
  - `rsp_valid`=0, `rsp_err`=0.
  - `rsp_lo`, `rsp_hi`, `mul_crs1`, `mul_crs2`, `mul_pw` and `mul_clmul` all 0.
- Reset mid-operation: return to IDLE next cycle, and drop `mul_valid` and `rsp_valid` without completing either handshake.
- Accept in cycle 0 → `mul_valid` high in cycle 1.
- `p_mul` handshake in cycle n → next half requested in cycle n+1, or `rsp_valid` in cycle n+1.
- With a 1-cycle `p_mul` (ready with valid), op=11 gives `rsp_valid` in cycle 3. Null/illegal requests give `rsp_valid` in cycle 1.
- `req_ready` is low outside IDLE. No request overlap: the next accept is at the earliest in the cycle after the response handshake.
- `req_ready`, `rsp_valid` and `mul_valid` are decoded from registered state only, with no combinational path from `mul_ready` or `rsp_ready`.

## Structure
- Shared package/include: state encodings, op codes (`OP_NULL`/`OP_LO`/`OP_HI`/`OP_BOTH`), pw one-hot constants (`PW_32`, `PW_16`), legal-pw check function.
- Sub-module `p_mul_seq_wdog`: counter with `clear`, `enable`, `MAX_WAIT` parameter and `expired` output.
- `p_mul` itself is instantiated by the parent, not inside this block.

## Test plan
- 32-bit op=11, crs1=crs2=0xFFFFFFFF, 1-cycle `p_mul` model → `rsp_lo`=0x00000001, `rsp_hi`=0xFFFFFFFE, `rsp_err`=0, `rsp_valid` in cycle 3.
- 16-bit op=01, crs1=0x00030002, crs2=0x00050004 → `rsp_lo`=0x00000008, `rsp_hi`=0, exactly one `p_mul` handshake with `mul_l`=1.
- op=10 with `p_mul` stalling 5 cycles, then `rsp_ready` low for 3 cycles → `mul_h`-only request; `rsp_*` stable while stalled; `req_ready` returns the cycle after the response handshake.
- `req_pw`=00100 or op=00 → `rsp_valid` in cycle 1 with `rsp_err`=1 or zero result respectively; `mul_valid` never asserted.
- `mul_ready` held low, `MAX_WAIT`=8 → abort after 8 cycles in LO with `rsp_err`=1. A separate case with ready on the limit cycle → normal completion.
- Assert `reset` in HI and in RSP → next cycle all outputs at reset values, and a following request completes correctly.
